// File: rtl/i2c_pkg.sv
// Shared encodings and the per-phase line-drive table for the I2C bit controller.
package i2c_pkg;

  localparam logic [1:0] CMD_START = 2'b00;
  localparam logic [1:0] CMD_STOP  = 2'b01;
  localparam logic [1:0] CMD_WRITE = 2'b10;
  localparam logic [1:0] CMD_READ  = 2'b11;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_PA   = 3'd1;
  localparam logic [2:0] ST_PB   = 3'd2;
  localparam logic [2:0] ST_PC   = 3'd3;
  localparam logic [2:0] ST_PD   = 3'd4;

  // 100 MHz / 250 / 4 = 100 kHz
  localparam int CLK_DIV_DEF = 250;

  // Open-drain enables {scl_oe, sda_oe} for a command in a given phase.
  // prev only matters for START phase A (repeated START keeps SCL low).
  function automatic logic [1:0] line_drive(input logic [2:0] st, input logic [1:0] cmd,
                                            input logic tx, input logic prev);
    logic [1:0] d;
    d = 2'b00;
    case (cmd)
      CMD_START: begin
        case (st)
          ST_PA:   d = {prev, 1'b0};
          ST_PC:   d = 2'b01;
          ST_PD:   d = 2'b11;
          default: d = 2'b00;
        endcase
      end
      CMD_STOP: begin
        case (st)
          ST_PA:        d = 2'b11;
          ST_PB, ST_PC: d = 2'b01;
          default:      d = 2'b00;
        endcase
      end
      CMD_WRITE: d = {(st == ST_PA) || (st == ST_PD), ~tx};
      default:   d = {(st == ST_PA) || (st == ST_PD), 1'b0};
    endcase
    return d;
  endfunction

endpackage

// File: rtl/i2c_bit_ctrl.sv
// Bit-level I2C master line controller: one START/STOP/WRITE/READ primitive
// per command, four quarter-bit phases each, with SCL stretching and
// arbitration-loss detection. Drives open-drain enables for the pads.
module i2c_bit_ctrl
  import i2c_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEF,
  parameter int CNT_W   = 16
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_cmd_valid,
  output logic       o_cmd_ready,
  input  logic [1:0] i_cmd,
  input  logic       i_tx_bit,
  output logic       o_rx_valid,
  output logic       o_rx_bit,
  output logic       o_arb_lost,
  output logic       o_busy,
  input  logic       i_scl,
  input  logic       i_sda,
  output logic       o_scl_oe,
  output logic       o_sda_oe
);

  localparam logic [CNT_W-1:0] LAST   = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] PENULT = CNT_W'(CLK_DIV - 2);

  logic [2:0]       st, st_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [1:0]       cmd_q, cmd_nxt;
  logic             bit_q, bit_nxt;
  logic             scl_prev, prev_nxt;
  logic             arb_nxt, rxv_nxt, drop, last, arb_chk;
  logic             rx_smp;

  assign o_cmd_ready = (st == ST_IDLE);
  assign o_busy      = ~o_cmd_ready;

  // Phase sequencing. The rx_valid and arb_lost pulses are decided one cycle
  // early so their registered outputs land on the last cycle of PD / PB.
  always_comb begin
    st_nxt   = st;
    cnt_nxt  = cnt;
    cmd_nxt  = cmd_q;
    bit_nxt  = bit_q;
    prev_nxt = scl_prev;
    arb_nxt  = 1'b0;
    rxv_nxt  = 1'b0;
    drop     = 1'b0;
    last     = (cnt == LAST);
    arb_chk  = (cmd_q == CMD_START) || ((cmd_q == CMD_WRITE) && bit_q);
    case (st)
      ST_IDLE: begin
        if (i_cmd_valid) begin
          st_nxt  = ST_PA;
          cnt_nxt = '0;
          cmd_nxt = i_cmd;
          bit_nxt = i_tx_bit;
        end
      end
      ST_PA: begin
        if (last) begin
          st_nxt  = ST_PB;
          cnt_nxt = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      ST_PB: begin
        if (last) begin
          cnt_nxt = '0;
          if (o_arb_lost) begin
            st_nxt   = ST_IDLE;
            prev_nxt = 1'b0;
            drop     = 1'b1;
          end else begin
            st_nxt = ST_PC;
          end
        end else if (i_scl) begin
          // Counter holds while SCL is seen low (slave stretch / filter lag).
          cnt_nxt = cnt + CNT_W'(1);
          arb_nxt = (cnt == PENULT) && arb_chk && !i_sda;
        end
      end
      ST_PC: begin
        if (last) begin
          st_nxt  = ST_PD;
          cnt_nxt = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      ST_PD: begin
        rxv_nxt = (cmd_q == CMD_READ) && (cnt == PENULT);
        if (last) begin
          st_nxt   = ST_IDLE;
          cnt_nxt  = '0;
          prev_nxt = (cmd_q != CMD_STOP);
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: begin
        st_nxt  = ST_IDLE;
        cnt_nxt = '0;
      end
    endcase
  end

  // State, counters and registered line drive; idle holds the last drive so
  // the bus stays owned between commands, arbitration loss releases it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      st         <= ST_IDLE;
      cnt        <= '0;
      cmd_q      <= CMD_START;
      bit_q      <= 1'b0;
      scl_prev   <= 1'b0;
      rx_smp     <= 1'b0;
      o_arb_lost <= 1'b0;
      o_rx_valid <= 1'b0;
      o_rx_bit   <= 1'b0;
      o_scl_oe   <= 1'b0;
      o_sda_oe   <= 1'b0;
    end else begin
      st         <= st_nxt;
      cnt        <= cnt_nxt;
      cmd_q      <= cmd_nxt;
      bit_q      <= bit_nxt;
      scl_prev   <= prev_nxt;
      o_arb_lost <= arb_nxt;
      o_rx_valid <= rxv_nxt;
      if (rxv_nxt) o_rx_bit <= rx_smp;
      if ((st == ST_PB) && last) rx_smp <= i_sda;
      if (drop) begin
        o_scl_oe <= 1'b0;
        o_sda_oe <= 1'b0;
      end else if (st_nxt != ST_IDLE) begin
        {o_scl_oe, o_sda_oe} <= line_drive(st_nxt, cmd_nxt, bit_nxt, prev_nxt);
      end
    end
  end

endmodule

// File: tb/tb_i2c_bit_ctrl.sv
// Directed bench for i2c_bit_ctrl with CLK_DIV=4 and a wired-AND loopback.
module tb_i2c_bit_ctrl;
  import i2c_pkg::*;

  logic       i_clk = 1'b0;
  logic       i_rst_n = 1'b0;
  logic       i_cmd_valid = 1'b0;
  logic [1:0] i_cmd = 2'b00;
  logic       i_tx_bit = 1'b0;
  logic       o_cmd_ready, o_rx_valid, o_rx_bit, o_arb_lost, o_busy;
  logic       o_scl_oe, o_sda_oe, i_scl, i_sda;
  logic       slave_scl_low = 1'b0;
  logic       slave_sda_low = 1'b0;

  assign i_scl = ~(o_scl_oe | slave_scl_low);
  assign i_sda = ~(o_sda_oe | slave_sda_low);

  i2c_bit_ctrl #(.CLK_DIV(4), .CNT_W(16)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
    .i_cmd(i_cmd), .i_tx_bit(i_tx_bit),
    .o_rx_valid(o_rx_valid), .o_rx_bit(o_rx_bit), .o_arb_lost(o_arb_lost),
    .o_busy(o_busy), .i_scl(i_scl), .i_sda(i_sda),
    .o_scl_oe(o_scl_oe), .o_sda_oe(o_sda_oe)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int failures = 0;

  // Capture of cycles 1..n after acceptance; bit k-1 holds cycle k.
  logic [63:0] cap_scl, cap_sda, cap_rxv, cap_arb, cap_rdy, cap_rxb;
  int s_from = 0;
  int s_to = 0;

  typedef struct {
    logic [1:0]  cmd;
    logic        tx;
    logic        sda_low;
    logic [15:0] scl;
    logic [15:0] sda;
    logic [15:0] rxv;
    logic [15:0] arb;
    logic [16:0] rdy;
    logic        chk_rxb;
    logic        rxb;
  } vec_t;

  vec_t vt[11];

  function automatic logic [15:0] ph(input logic a, input logic b, input logic c, input logic d);
    return {{4{d}}, {4{c}}, {4{b}}, {4{a}}};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, act, exp);
    end
  endtask

  // Issue one command and record n cycles of outputs.
  task automatic run_cmd(input logic [1:0] c, input logic b, input int n);
    int guard;
    guard = 0;
    cap_scl = '0; cap_sda = '0; cap_rxv = '0; cap_arb = '0; cap_rdy = '0; cap_rxb = '0;
    @(negedge i_clk);
    while (!o_cmd_ready && guard < 100) begin
      @(negedge i_clk);
      guard++;
    end
    if (!o_cmd_ready) begin
      checks++;
      failures++;
      $display("FAIL ready_timeout got=0 exp=1");
    end
    i_cmd = c;
    i_tx_bit = b;
    i_cmd_valid = 1'b1;
    @(posedge i_clk);
    #1;
    i_cmd_valid = 1'b0;
    for (int k = 1; k <= n; k++) begin
      if (k > 1) begin
        @(posedge i_clk);
        #1;
      end
      if (k == s_from) slave_scl_low = 1'b1;
      if (k == s_to) slave_scl_low = 1'b0;
      cap_scl[k-1] = o_scl_oe;
      cap_sda[k-1] = o_sda_oe;
      cap_rxv[k-1] = o_rx_valid;
      cap_arb[k-1] = o_arb_lost;
      cap_rdy[k-1] = o_cmd_ready;
      cap_rxb[k-1] = o_rx_bit;
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog_timeout got=running exp=finished");
    $fatal(1);
  end

  initial begin
    //            cmd        tx    slo   scl             sda             rxv       arb       rdy        crx   rxb
    vt[0]  = '{CMD_START, 1'b0, 1'b0, ph(0,0,0,1), ph(0,0,1,1), 16'h0000, 16'h0000, 17'h10000, 1'b0, 1'b0};
    vt[1]  = '{CMD_WRITE, 1'b0, 1'b0, ph(1,0,0,1), ph(1,1,1,1), 16'h0000, 16'h0000, 17'h10000, 1'b0, 1'b0};
    vt[2]  = '{CMD_WRITE, 1'b1, 1'b0, ph(1,0,0,1), ph(0,0,0,0), 16'h0000, 16'h0000, 17'h10000, 1'b0, 1'b0};
    vt[3]  = '{CMD_READ,  1'b0, 1'b1, ph(1,0,0,1), ph(0,0,0,0), 16'h8000, 16'h0000, 17'h10000, 1'b1, 1'b0};
    vt[4]  = '{CMD_READ,  1'b0, 1'b0, ph(1,0,0,1), ph(0,0,0,0), 16'h8000, 16'h0000, 17'h10000, 1'b1, 1'b1};
    vt[5]  = '{CMD_START, 1'b0, 1'b0, ph(1,0,0,1), ph(0,0,1,1), 16'h0000, 16'h0000, 17'h10000, 1'b0, 1'b0};
    vt[6]  = '{CMD_STOP,  1'b0, 1'b0, ph(1,0,0,0), ph(1,1,1,0), 16'h0000, 16'h0000, 17'h10000, 1'b0, 1'b0};
    vt[7]  = '{CMD_START, 1'b0, 1'b0, ph(0,0,0,1), ph(0,0,1,1), 16'h0000, 16'h0000, 17'h10000, 1'b0, 1'b0};
    vt[8]  = '{CMD_WRITE, 1'b1, 1'b1, ph(1,0,0,0), ph(0,0,0,0), 16'h0000, 16'h0080, 17'h1FF00, 1'b0, 1'b0};
    vt[9]  = '{CMD_START, 1'b0, 1'b0, ph(0,0,0,1), ph(0,0,1,1), 16'h0000, 16'h0000, 17'h10000, 1'b0, 1'b0};
    vt[10] = '{CMD_STOP,  1'b0, 1'b0, ph(1,0,0,0), ph(1,1,1,0), 16'h0000, 16'h0000, 17'h10000, 1'b0, 1'b0};

    // Reset state
    repeat (3) @(posedge i_clk);
    #1;
    chk("rst_oe", {62'd0, o_scl_oe, o_sda_oe}, 64'd0);
    chk("rst_pulses", {61'd0, o_rx_valid, o_rx_bit, o_arb_lost}, 64'd0);
    chk("rst_ready_busy", {62'd0, o_cmd_ready, o_busy}, 64'd2);
    @(negedge i_clk);
    i_rst_n = 1'b1;

    // Table of single commands, each observed for 17 cycles
    for (int i = 0; i < 11; i++) begin
      slave_sda_low = vt[i].sda_low;
      run_cmd(vt[i].cmd, vt[i].tx, 17);
      slave_sda_low = 1'b0;
      chk($sformatf("v%0d_scl", i), {48'd0, cap_scl[15:0]}, {48'd0, vt[i].scl});
      chk($sformatf("v%0d_sda", i), {48'd0, cap_sda[15:0]}, {48'd0, vt[i].sda});
      chk($sformatf("v%0d_rxv", i), {47'd0, cap_rxv[16:0]}, {48'd0, vt[i].rxv});
      chk($sformatf("v%0d_arb", i), {47'd0, cap_arb[16:0]}, {48'd0, vt[i].arb});
      chk($sformatf("v%0d_rdy", i), {47'd0, cap_rdy[16:0]}, {47'd0, vt[i].rdy});
      if (vt[i].chk_rxb) chk($sformatf("v%0d_rxb", i), {63'd0, cap_rxb[15]}, {63'd0, vt[i].rxb});
    end

    // Clock stretch: slave holds SCL low for cycles 5..24 of a WRITE 0
    run_cmd(CMD_START, 1'b0, 17);
    s_from = 4;
    s_to = 25;
    run_cmd(CMD_WRITE, 1'b0, 40);
    s_from = 0;
    s_to = 0;
    chk("stretch_rdy", {27'd0, cap_rdy[36:0]}, {27'd0, 37'h10_0000_0000});
    chk("stretch_scl", {28'd0, cap_scl[35:0]}, {28'd0, 36'hF_0000_000F});
    chk("stretch_sda", {28'd0, cap_sda[35:0]}, {28'd0, 36'hF_FFFF_FFFF});
    chk("stretch_arb", cap_arb[39:0], 40'd0);

    // Reset in the middle of a WRITE while SCL is driven low
    run_cmd(CMD_WRITE, 1'b0, 2);
    chk("midrst_pre_scl", {63'd0, cap_scl[1]}, 64'd1);
    #2;
    i_rst_n = 1'b0;
    #1;
    chk("midrst_oe", {62'd0, o_scl_oe, o_sda_oe}, 64'd0);
    chk("midrst_ready_busy", {62'd0, o_cmd_ready, o_busy}, 64'd2);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;
    chk("postrst_state", {60'd0, o_cmd_ready, o_busy, o_scl_oe, o_sda_oe}, 64'd8);
    chk("postrst_rxb", {63'd0, o_rx_bit}, 64'd0);

    // START after reset must not hold SCL in phase A
    run_cmd(CMD_START, 1'b0, 17);
    chk("postrst_start_scl", {48'd0, cap_scl[15:0]}, {48'd0, ph(0,0,0,1)});
    chk("postrst_start_sda", {48'd0, cap_sda[15:0]}, {48'd0, ph(0,0,1,1)});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/i2c_bit_ctrl.md
Name: i2c_bit_ctrl

Overview:
Bit-level I2C master line controller: the drive-side counterpart to the I2C input filter. Executes one bus primitive per command (START, STOP, WRITE bit, READ bit), generating SCL/SDA open-drain enables with quarter-period timing. Supports clock stretching and arbitration-loss detection. Sits between a byte-level I2C master FSM and the pad open-drain buffers. i_scl/i_sda come from i2c_filter instances on the pad inputs.

Parameters:
CLK_DIV, 250, clocks per quarter bit period (100 MHz / 250 / 4 = 100 kHz); legal range 4..2^CNT_W-1
CNT_W, 16, width of the phase counter

Ports:
i_clk  input  1  system clock
i_rst_n  input  1  reset, asynchronous, active-low
i_cmd_valid  input  1  command request
o_cmd_ready  output  1  high when idle and able to accept a command
i_cmd  input  2  00 START, 01 STOP, 10 WRITE, 11 READ
i_tx_bit  input  1  bit to send for WRITE; sampled at acceptance
o_rx_valid  output  1  one-cycle pulse at READ completion
o_rx_bit  output  1  bit read; held until the next READ completes
o_arb_lost  output  1  one-cycle pulse on arbitration loss
o_busy  output  1  high while a command executes
i_scl  input  1  filtered SCL pad level
i_sda  input  1  filtered SDA pad level
o_scl_oe  output  1  1 = drive SCL low, 0 = release
o_sda_oe  output  1  1 = drive SDA low, 0 = release

Behaviour:
- Reset (async, i_rst_n=0): state IDLE, o_scl_oe=0, o_sda_oe=0, o_rx_valid=0, o_rx_bit=0, o_arb_lost=0, o_busy=0, counter=0, scl_prev=0. Reset mid-command releases both lines immediately. No pending command survives reset.
- States: IDLE, PA, PB, PC, PD. o_cmd_ready = (state==IDLE). o_busy = !o_cmd_ready.
- Accept on i_cmd_valid & o_cmd_ready. Latch cmd and tx_bit, go to PA with counter=0.
- Each phase lasts CLK_DIV cycles. Advance when counter==CLK_DIV-1. PD end -> IDLE, so o_cmd_ready is high on the next cycle.
- Line drive per phase (L = low, R = release, P = hold scl_prev):
  START: PA scl P / sda R; PB R/R; PC R/L; PD L/L.
  STOP: PA L/L; PB R/L; PC R/L; PD R/R.
  WRITE: PA L/~bit; PB R/~bit; PC R/~bit; PD L/~bit.
  READ: PA L/R; PB R/R; PC R/R; PD L/R.
- scl_prev: cleared by STOP completion and reset. Set by START/WRITE/READ completion. It provides repeated-START support.
- Clock stretching: in PB the counter holds while i_scl==0. Counting starts once SCL is observed high, so filter latency also extends PB.
- READ: sample i_sda on the last cycle of PB into o_rx_bit. Pulse o_rx_valid on the last cycle of PD.
- Arbitration: on the last PB cycle of WRITE with bit=1, or START, if i_sda==0:
  - Pulse o_arb_lost.
  - Release both lines next cycle.
  - Go to IDLE and clear scl_prev. No o_rx_valid.
- Simultaneous i_cmd_valid during a busy state is ignored; the requester must hold valid.
- Outputs are registered. The first line change after acceptance appears in the cycle following acceptance.

Decomposition:
- Package i2c_pkg:
  - Command encodings CMD_START/CMD_STOP/CMD_WRITE/CMD_READ.
  - State encodings.
  - Default CLK_DIV.
- No sub-module. The phase counter is inline.
- i2c_filter instances are placed by the parent, not here.

Test Plan:
Bench uses CLK_DIV=4 and a zero-latency wired-AND loopback: i_scl = ~(o_scl_oe | slave_scl_low), same for SDA.
- Reset: assert i_rst_n=0 mid-WRITE (o_scl_oe=1) -> both oe=0 within the same cycle. After release, o_cmd_ready=1 and o_busy=0.
- START from idle -> o_sda_oe rises at cycle 9 after accept and o_scl_oe at cycle 13. o_cmd_ready returns at cycle 17. Then STOP -> both oe=0 after 16 cycles.
- WRITE tx_bit=0 then tx_bit=1 -> o_sda_oe=1 then 0 for the full 16 cycles each. o_scl_oe pattern is 1,0,0,1 per 4-cycle phase. No o_arb_lost.
- READ with slave pulling SDA low -> o_rx_valid one-cycle pulse at cycle 16 with o_rx_bit=0. Repeat with SDA released -> o_rx_bit=1.
- Clock stretch: slave holds SCL low 20 cycles into PB of a WRITE -> completion delayed by exactly 20 cycles. Line pattern is otherwise unchanged.
- Arbitration: WRITE tx_bit=1 while another master drives SDA low -> o_arb_lost pulses at cycle 8 and both oe=0 at cycle 9. o_cmd_ready=1, no o_rx_valid, and the next START begins with scl_prev=0.
